// File: rtl/ahb_apb_pkg.sv
// Shared types and address-decode constants for the AHB-to-APB bridge core.
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WWAIT,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } apb_state_e;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // Peripheral select comes from the top six address bits.
    localparam int unsigned DEC_MSB = 31;
    localparam int unsigned DEC_LSB = 26;
    localparam int unsigned DEC_W   = DEC_MSB - DEC_LSB + 1;

    localparam int unsigned MAX_SLV = 4;
    localparam logic [31:0] SLV_BASE [MAX_SLV] = '{
        32'h8000_0000,
        32'h8400_0000,
        32'h8800_0000,
        32'h8C00_0000
    };

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational peripheral decode: address field to in_range flag and one-hot select.
module apb_addr_decoder
    import ahb_apb_pkg::*;
#(
    parameter int unsigned NSLV = 4
) (
    input  logic [DEC_W-1:0] dec_field,
    output logic             in_range,
    output logic [NSLV-1:0]  sel
);

    always_comb begin
        sel = '0;
        for (int i = 0; i < int'(NSLV); i++) begin
            sel[i] = (dec_field == SLV_BASE[i][DEC_MSB:DEC_LSB]);
        end
        in_range = |sel;
    end

endmodule

// File: rtl/apb_fsm_controller.sv
// AHB-to-APB bridge core: one outstanding transfer, pipelined through ACCESS.
// Define APB_ERR_RESP_EN to answer out-of-range transfers with a two-cycle ERROR.
module apb_fsm_controller
    import ahb_apb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NSLV   = 4
) (
    input  logic              clk,
    input  logic              Hresetn,
    input  logic [1:0]        Htrans,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic              Hwrite,
    input  logic              Hreadyin,
    input  logic [2:0]        Hburst,
    input  logic [2:0]        Hsize,
    input  logic [DATA_W-1:0] Prdata,
    output logic              Hreadyout,
    output logic [DATA_W-1:0] Hrdata,
    output logic [1:0]        Hresp,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic [NSLV-1:0]   Pselx,
    output logic              Penable,
    output logic              Pwrite
);

    apb_state_e        state;
    logic [ADDR_W-1:0] addr_q;
    logic [NSLV-1:0]   sel_q;

    logic              in_range;
    logic [NSLV-1:0]   dec_sel;
    logic              xfer_type;
    logic              accept_rd;
    logic              accept_wr;
    logic              accept_err;

    logic unused_inputs;
    assign unused_inputs = ^{Hburst, Hsize};

    apb_addr_decoder #(
        .NSLV (NSLV)
    ) u_decoder (
        .dec_field (Haddr[DEC_MSB:DEC_LSB]),
        .in_range  (in_range),
        .sel       (dec_sel)
    );

    // Hreadyout is high only in states that may take a new address phase.
    assign xfer_type  = Hreadyin & (htrans_e'(Htrans) inside {HTRANS_NONSEQ, HTRANS_SEQ});
    assign accept_rd  = Hreadyout & xfer_type & in_range & ~Hwrite;
    assign accept_wr  = Hreadyout & xfer_type & in_range & Hwrite;
    assign accept_err = Hreadyout & xfer_type & ~in_range;

    always_ff @(posedge clk or negedge Hresetn) begin
        if (!Hresetn) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            sel_q     <= '0;
            Hreadyout <= 1'b1;
            Hresp     <= HRESP_OKAY;
            Paddr     <= '0;
            Pwdata    <= '0;
            Pselx     <= '0;
            Penable   <= 1'b0;
            Pwrite    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_ACCESS, ST_ERR2: begin
                    Penable <= 1'b0;
                    if (accept_rd) begin
                        // Reads go straight to SETUP, so APB address is driven now.
                        state     <= ST_SETUP;
                        addr_q    <= Haddr;
                        sel_q     <= dec_sel;
                        Paddr     <= Haddr;
                        Pwrite    <= 1'b0;
                        Pselx     <= dec_sel;
                        Hreadyout <= 1'b0;
                        Hresp     <= HRESP_OKAY;
                    end else if (accept_wr) begin
                        state     <= ST_WWAIT;
                        addr_q    <= Haddr;
                        sel_q     <= dec_sel;
                        Pselx     <= '0;
                        Hreadyout <= 1'b0;
                        Hresp     <= HRESP_OKAY;
`ifdef APB_ERR_RESP_EN
                    end else if (accept_err) begin
                        state     <= ST_ERR1;
                        Pselx     <= '0;
                        Hreadyout <= 1'b0;
                        Hresp     <= HRESP_ERROR;
`endif
                    end else begin
                        state     <= ST_IDLE;
                        Pselx     <= '0;
                        Hreadyout <= 1'b1;
                        Hresp     <= HRESP_OKAY;
                    end
                end
                ST_WWAIT: begin
                    state     <= ST_SETUP;
                    Pwdata    <= Hwdata;
                    Paddr     <= addr_q;
                    Pwrite    <= 1'b1;
                    Pselx     <= sel_q;
                    Penable   <= 1'b0;
                    Hreadyout <= 1'b0;
                end
                ST_SETUP: begin
                    state     <= ST_ACCESS;
                    Penable   <= 1'b1;
                    Hreadyout <= 1'b1;
                end
`ifdef APB_ERR_RESP_EN
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    Hreadyout <= 1'b1;
                    Hresp     <= HRESP_ERROR;
                end
`endif
                default: begin
                    state     <= ST_IDLE;
                    Pselx     <= '0;
                    Penable   <= 1'b0;
                    Hreadyout <= 1'b1;
                    Hresp     <= HRESP_OKAY;
                end
            endcase
        end
    end

    // Combinational so read data lines up with the cycle Hreadyout is high.
    always_comb begin
        Hrdata = '0;
        if (state == ST_ACCESS && !Pwrite) begin
            Hrdata = Prdata;
        end
    end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Scoreboard bench for apb_fsm_controller; honours APB_ERR_RESP_EN when defined.
module tb_apb_fsm_controller;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [31:0] RD_MASK = 32'hA5A5_5A5A;

    logic        clk;
    logic        Hresetn;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic        Hwrite;
    logic        Hreadyin;
    logic [2:0]  Hburst;
    logic [2:0]  Hsize;
    logic [31:0] Prdata;
    logic        Hreadyout;
    logic [31:0] Hrdata;
    logic [1:0]  Hresp;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [3:0]  Pselx;
    logic        Penable;
    logic        Pwrite;

    typedef struct packed {
        logic [3:0]  sel;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } apb_exp_t;

    apb_exp_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    logic        use_fixed;
    logic [31:0] fixed_rd;

    // Peripheral model: fixed word, or a pattern derived from the APB address.
    assign Prdata = use_fixed ? fixed_rd : (Paddr ^ RD_MASK);

    apb_fsm_controller u_dut (
        .clk       (clk),
        .Hresetn   (Hresetn),
        .Htrans    (Htrans),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .Hwrite    (Hwrite),
        .Hreadyin  (Hreadyin),
        .Hburst    (Hburst),
        .Hsize     (Hsize),
        .Prdata    (Prdata),
        .Hreadyout (Hreadyout),
        .Hrdata    (Hrdata),
        .Hresp     (Hresp),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_addr(input logic [1:0] tr, input logic [31:0] a, input logic w);
        Htrans   = tr;
        Haddr    = a;
        Hwrite   = w;
        Hreadyin = 1'b1;
        Hburst   = 3'($urandom);
        Hsize    = 3'($urandom);
    endtask

    // Counts data-phase cycles with Hreadyout low; returns at the negedge where it is high.
    task automatic wait_ready(input string tag, output int waits);
        waits = 0;
        @(negedge clk);
        while (!Hreadyout && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (!Hreadyout) check({tag, "_timeout"}, 64'd1, 64'd0);
    endtask

    function automatic logic [3:0] exp_sel(input logic [31:0] a);
        case (a[31:26])
            6'h20:   return 4'b0001;
            6'h21:   return 4'b0010;
            6'h22:   return 4'b0100;
            6'h23:   return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        return use_fixed ? fixed_rd : (a ^ RD_MASK);
    endfunction

    task automatic push_exp(input logic [31:0] a, input logic w, input logic [31:0] wd);
        apb_exp_t e;
        e.sel   = exp_sel(a);
        e.addr  = a;
        e.write = w;
        e.wdata = w ? wd : 32'h0;
        e.rdata = w ? 32'h0 : exp_rdata(a);
        exp_q.push_back(e);
    endtask

    // One non-pipelined transfer from IDLE; checks wait states and response.
    task automatic xfer(input string tag, input logic [31:0] a, input logic w,
                        input logic [31:0] wd);
        int waits;
        int exp_w;
        logic inr;
        inr = (exp_sel(a) != 4'b0000);
        if (inr) begin
            push_exp(a, w, wd);
            exp_w = w ? 2 : 1;
        end else begin
`ifdef APB_ERR_RESP_EN
            exp_w = 1;
`else
            exp_w = 0;
`endif
        end
        drive_addr(T_NONSEQ, a, w);
        tick();
        Htrans = T_IDLE;
        Hwdata = wd;
        wait_ready(tag, waits);
        check({tag, "_waits"}, 64'(waits), 64'(exp_w));
        if (!inr) begin
`ifdef APB_ERR_RESP_EN
            check({tag, "_hresp"}, 64'(Hresp), 64'd1);
`else
            check({tag, "_hresp"}, 64'(Hresp), 64'd0);
`endif
        end
        tick();
    endtask

    // APB-side monitor: SETUP must match the head of the scoreboard, ACCESS retires it.
    always @(negedge clk) begin
        apb_exp_t e;
        if (Hresetn) begin
            if (Penable) begin
                if (exp_q.size() == 0) begin
                    check("apb_unexpected_access", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("acc_sel", 64'(Pselx), 64'(e.sel));
                    check("acc_addr", 64'(Paddr), 64'(e.addr));
                    check("acc_write", 64'(Pwrite), 64'(e.write));
                    check("acc_ready", 64'(Hreadyout), 64'd1);
                    if (e.write) check("acc_wdata", 64'(Pwdata), 64'(e.wdata));
                    check("acc_hrdata", 64'(Hrdata), 64'(e.rdata));
                end
            end else if (|Pselx) begin
                if (exp_q.size() == 0) begin
                    check("apb_unexpected_setup", 64'd1, 64'd0);
                end else begin
                    check("setup_sel", 64'(Pselx), 64'(exp_q[0].sel));
                    check("setup_addr", 64'(Paddr), 64'(exp_q[0].addr));
                    check("setup_ready", 64'(Hreadyout), 64'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waits;
        logic [5:0] f;
        Hresetn   = 1'b0;
        Htrans    = T_IDLE;
        Haddr     = 32'h0;
        Hwdata    = 32'h0;
        Hwrite    = 1'b0;
        Hreadyin  = 1'b1;
        Hburst    = 3'd0;
        Hsize     = 3'd2;
        use_fixed = 1'b0;
        fixed_rd  = 32'h0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_hreadyout", 64'(Hreadyout), 64'd1);
        check("rst_hresp", 64'(Hresp), 64'd0);
        check("rst_hrdata", 64'(Hrdata), 64'd0);
        check("rst_paddr", 64'(Paddr), 64'd0);
        check("rst_pwdata", 64'(Pwdata), 64'd0);
        check("rst_pselx", 64'(Pselx), 64'd0);
        check("rst_penable", 64'(Penable), 64'd0);
        check("rst_pwrite", 64'(Pwrite), 64'd0);
        tick();
        Hresetn = 1'b1;
        tick();

        // Directed read and write
        use_fixed = 1'b1;
        fixed_rd  = 32'hDEAD_BEEF;
        xfer("rd0", 32'h8000_0010, 1'b0, 32'h0);
        use_fixed = 1'b0;
        xfer("wr1", 32'h8400_0004, 1'b1, 32'h1234_5678);
        check("wr1_pwdata_hold", 64'(Pwdata), 64'h1234_5678);
        check("wr1_pwrite_hold", 64'(Pwrite), 64'd1);

        // Back-to-back reads: second address presented during the first ACCESS
        push_exp(32'h8800_0000, 1'b0, 32'h0);
        drive_addr(T_NONSEQ, 32'h8800_0000, 1'b0);
        tick();
        Htrans = T_IDLE;
        wait_ready("b2b_a", waits);
        check("b2b_a_waits", 64'(waits), 64'd1);
        push_exp(32'h8C00_0000, 1'b0, 32'h0);
        drive_addr(T_NONSEQ, 32'h8C00_0000, 1'b0);
        tick();
        Htrans = T_IDLE;
        wait_ready("b2b_b", waits);
        check("b2b_b_waits", 64'(waits), 64'd1);
        tick();

        // Read then pipelined write: select drops for the WWAIT cycle
        push_exp(32'h8000_0100, 1'b0, 32'h0);
        drive_addr(T_NONSEQ, 32'h8000_0100, 1'b0);
        tick();
        Htrans = T_IDLE;
        wait_ready("rw_a", waits);
        push_exp(32'h8400_0100, 1'b1, 32'hCAFE_F00D);
        drive_addr(T_NONSEQ, 32'h8400_0100, 1'b1);
        tick();
        Htrans = T_IDLE;
        Hwdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("rw_wwait_sel", 64'(Pselx), 64'd0);
        check("rw_wwait_ready", 64'(Hreadyout), 64'd0);
        wait_ready("rw_b", waits);
        check("rw_b_waits", 64'(waits), 64'd1);
        tick();

        // BUSY, then NONSEQ with Hreadyin low: never accepted
        drive_addr(T_BUSY, 32'h8000_0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("busy_sel", 64'(Pselx), 64'd0);
            check("busy_ready", 64'(Hreadyout), 64'd1);
        end
        drive_addr(T_NONSEQ, 32'h8000_0000, 1'b0);
        Hreadyin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("nordy_sel", 64'(Pselx), 64'd0);
            check("nordy_ready", 64'(Hreadyout), 64'd1);
        end
        tick();
        Htrans   = T_IDLE;
        Hreadyin = 1'b1;
        tick();

        // Out-of-range read
        drive_addr(T_NONSEQ, 32'h9000_0000, 1'b0);
        tick();
        Htrans = T_IDLE;
        @(negedge clk);
`ifdef APB_ERR_RESP_EN
        check("err1_ready", 64'(Hreadyout), 64'd0);
        check("err1_resp", 64'(Hresp), 64'd1);
        @(negedge clk);
        check("err2_ready", 64'(Hreadyout), 64'd1);
        check("err2_resp", 64'(Hresp), 64'd1);
        @(negedge clk);
        check("err_after_resp", 64'(Hresp), 64'd0);
`else
        check("oor_ready", 64'(Hreadyout), 64'd1);
        check("oor_resp", 64'(Hresp), 64'd0);
`endif
        check("oor_sel", 64'(Pselx), 64'd0);
        tick();

        // Reset during the ACCESS cycle of a write
        push_exp(32'h8C00_0008, 1'b1, 32'h5555_AAAA);
        drive_addr(T_NONSEQ, 32'h8C00_0008, 1'b1);
        tick();
        Htrans = T_IDLE;
        Hwdata = 32'h5555_AAAA;
        wait_ready("rst_wr", waits);
        #1;
        Hresetn = 1'b0;
        #1;
        check("arst_pselx", 64'(Pselx), 64'd0);
        check("arst_penable", 64'(Penable), 64'd0);
        check("arst_ready", 64'(Hreadyout), 64'd1);
        check("arst_paddr", 64'(Paddr), 64'd0);
        #1;
        Hresetn = 1'b1;
        tick();
        xfer("post_rst", 32'h8000_0020, 1'b0, 32'h0);

        // Random single transfers, including out-of-range addresses
        for (int i = 0; i < 24; i++) begin
            int pick;
            pick = $urandom_range(0, 4);
            f = (pick == 4) ? 6'($urandom_range(36, 63)) : 6'(32 + pick);
            xfer("rand", {f, 26'($urandom)}, 1'($urandom), $urandom);
        end

        repeat (3) tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
